// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: valid/ready byte in, framed serial line out
module uart_tx_core #(
  parameter int CLK_FREQ = 100000000,
  parameter int DIV_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bd_sel,
  input  logic [1:0] prty_sel,
  input  logic       stop_sel,
  input  logic       data_bit_sel,
  input  logic [7:0] data_in_Tx,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_out_Tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [DIV_W-1:0] CYC_1200 = DIV_W'(CLK_FREQ / 1200);
  localparam logic [DIV_W-1:0] CYC_2400 = DIV_W'(CLK_FREQ / 2400);
  localparam logic [DIV_W-1:0] CYC_4800 = DIV_W'(CLK_FREQ / 4800);
  localparam logic [DIV_W-1:0] CYC_9600 = DIV_W'(CLK_FREQ / 9600);

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] bit_cyc_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic             eight_q;
  logic             par_en_q;
  logic             par_bit_q;
  logic             two_stop_q;
  logic             stop_cnt_q;
  logic             line_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [DIV_W-1:0] bit_cyc_d;
  logic [7:0]       data_d;
  logic             par_bit_d;
  logic             par_en_d;
  logic             tick;

  // Per-frame settings derived from the live selectors; only sampled at acceptance
  always_comb begin
    bit_cyc_d = CYC_9600;
    case (bd_sel)
      2'b00:   bit_cyc_d = CYC_1200;
      2'b01:   bit_cyc_d = CYC_2400;
      2'b10:   bit_cyc_d = CYC_4800;
      default: bit_cyc_d = CYC_9600;
    endcase
    data_d    = data_bit_sel ? data_in_Tx : {1'b0, data_in_Tx[6:0]};
    par_en_d  = (prty_sel == 2'b01) || (prty_sel == 2'b10);
    par_bit_d = (^data_d) ^ (prty_sel == 2'b01);
  end

  assign tick = (div_q == bit_cyc_q - DIV_W'(1));

  // Frame sequencer; line and handshake outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_cyc_q  <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      eight_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (tx_valid) begin
            state_q    <= S_START;
            div_q      <= '0;
            bit_cyc_q  <= bit_cyc_d;
            shift_q    <= data_d;
            eight_q    <= data_bit_sel;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= stop_sel;
            line_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            line_q    <= shift_q[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == (eight_q ? 3'd7 : 3'd6)) begin
              if (par_en_q) begin
                state_q <= S_PARITY;
                line_q  <= par_bit_q;
              end else begin
                state_q    <= S_STOP;
                stop_cnt_q <= 1'b0;
                line_q     <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              line_q    <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state_q    <= S_STOP;
            stop_cnt_q <= 1'b0;
            line_q     <= 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (two_stop_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          line_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign data_out_Tx = line_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core
module tb_uart_tx_core;

  localparam int CLK_FREQ = 96000;
  localparam int B9600 = CLK_FREQ / 9600;
  localparam int B4800 = CLK_FREQ / 4800;
  localparam int B1200 = CLK_FREQ / 1200;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bd_sel;
  logic [1:0] prty_sel;
  logic       stop_sel;
  logic       data_bit_sel;
  logic [7:0] data_in_Tx;
  logic       tx_valid;
  logic       tx_ready;
  logic       data_out_Tx;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.CLK_FREQ(CLK_FREQ), .DIV_W(17)) dut (
    .clk(clk),
    .rst(rst),
    .bd_sel(bd_sel),
    .prty_sel(prty_sel),
    .stop_sel(stop_sel),
    .data_bit_sel(data_bit_sel),
    .data_in_Tx(data_in_Tx),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .data_out_Tx(data_out_Tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] b, input logic [1:0] bd, input logic [1:0] pr,
                             input logic st, input logic db, input bit hold);
    @(negedge clk);
    data_in_Tx   = b;
    bd_sel       = bd;
    prty_sel     = pr;
    stop_sel     = st;
    data_bit_sel = db;
    tx_valid     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic capture(input string tag, input int nb, input int bc, input logic [11:0] exp,
                         input int ev_cyc, input logic [1:0] ev_bd, input bit ev_pulse);
    logic [11:0] sb;
    logic [11:0] eb;
    int first_done;
    int n_done;
    int rdy_hi;
    sb = '0;
    eb = '0;
    first_done = -1;
    n_done = 0;
    rdy_hi = 0;
    for (int c = 1; c <= nb * bc + 1; c++) begin
      @(negedge clk);
      if (c == ev_cyc) begin
        bd_sel = ev_bd;
        if (ev_pulse) tx_valid = 1'b1;
      end else if (ev_pulse && c == ev_cyc + 1) begin
        tx_valid = 1'b0;
      end
      if (c <= nb * bc) begin
        if ((c - 1) % bc == 0) sb[(c - 1) / bc] = data_out_Tx;
        if (c % bc == 0) eb[c / bc - 1] = data_out_Tx;
        if (tx_ready) rdy_hi++;
      end
      if (tx_done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    check_val({tag, "_bits_start"}, 32'(sb), 32'(exp));
    check_val({tag, "_bits_end"}, 32'(eb), 32'(exp));
    check_val({tag, "_done_cycle"}, first_done, nb * bc + 1);
    check_val({tag, "_done_count"}, n_done, 1);
    check_val({tag, "_ready_low"}, rdy_hi, 0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    int lows;
    int dones;
    int busys;
    lows = 0;
    dones = 0;
    busys = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!data_out_Tx) lows++;
      if (tx_done) dones++;
      if (tx_busy) busys++;
    end
    check_val({tag, "_line_low"}, lows, 0);
    check_val({tag, "_done"}, dones, 0);
    check_val({tag, "_busy"}, busys, 0);
  endtask

  initial begin
    rst = 1'b1;
    bd_sel = 2'b11;
    prty_sel = 2'b00;
    stop_sel = 1'b0;
    data_bit_sel = 1'b1;
    data_in_Tx = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_line", 32'(data_out_Tx), 32'd1);
    check_val("rst_ready", 32'(tx_ready), 32'd1);
    check_val("rst_busy", 32'(tx_busy), 32'd0);
    check_val("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 9600 8N1 0x55, with a stray tx_valid pulse mid-frame that must be ignored
    start_frame(8'h55, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    check_val("f55_busy", 32'(tx_busy), 32'd1);
    capture("f55", 10, B9600, 12'h2AA, 30, 2'b11, 1'b1);
    watch_idle("f55_after", 30);

    // 1200 7E2 0x41 -> 0,1,0,0,0,0,0,1,0,1,1
    start_frame(8'h41, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
    capture("f41", 11, B1200, 12'h682, 0, 2'b00, 1'b0);

    // 4800 8O1 0xFF -> parity 1
    start_frame(8'hFF, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
    capture("fff", 11, B4800, 12'h7FE, 0, 2'b10, 1'b0);

    // back-to-back 0xA5 then 0x3C with tx_valid held high
    start_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
    data_in_Tx = 8'h3C;
    capture("fa5", 10, B9600, 12'h34A, 0, 2'b11, 1'b0);
    capture("f3c", 10, B9600, 12'h278, 5, 2'b11, 1'b1);
    watch_idle("f3c_after", 20);

    // baud selector changed mid-frame: current frame stays 9600, next is 1200
    start_frame(8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    capture("fbd9600", 10, B9600, 12'h200, 35, 2'b00, 1'b0);
    start_frame(8'h55, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    capture("fbd1200", 10, B1200, 12'h2AA, 0, 2'b00, 1'b0);

    // reset during DATA
    start_frame(8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    repeat (25) @(negedge clk);
    check_val("mid_line_before", 32'(data_out_Tx), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_line", 32'(data_out_Tx), 32'd1);
    check_val("mid_rst_ready", 32'(tx_ready), 32'd1);
    check_val("mid_rst_busy", 32'(tx_busy), 32'd0);
    check_val("mid_rst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_idle("mid_rst_after", 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Serial UART transmitter, the send-side counterpart of the receive top. Takes one parallel byte through a valid/ready handshake and shifts out a frame: start bit, data bits LSB first, optional parity, stop bits. The baud tick is generated internally from the system clock. Baud rate, data width, parity and stop-bit count are run-time selectable with the same selector encoding as the receiver.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz; used to derive the per-bit divider values
DIV_W, 17, width of the baud divider counter; must hold CLK_FREQ/1200

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
bd_sel  input  2  baud select: 00=1200, 01=2400, 10=4800, 11=9600
prty_sel  input  2  parity: 00=none, 01=odd, 10=even, 11=none
stop_sel  input  1  0=one stop bit, 1=two stop bits
data_bit_sel  input  1  0=7 data bits, 1=8 data bits
data_in_Tx  input  8  parallel byte to send; bit 7 ignored when 7-bit mode is selected
tx_valid  input  1  data_in_Tx is valid and a send is requested
tx_ready  output  1  block can accept a byte (IDLE)
data_out_Tx  output  1  serial line, idle high
tx_busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (synchronous, on a clk edge with rst=1): state=IDLE, data_out_Tx=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
- Bit period: BIT_CYC = CLK_FREQ/baud, integer-truncated. The divider counts 0..BIT_CYC-1; the bit boundary is at terminal count.
- Handshake: the byte is accepted on the cycle where tx_valid=1 and tx_ready=1. On acceptance the block latches data_in_Tx and all four selectors. Selector changes mid-frame have no effect on the current frame.
- Parity bit: XOR of the active data bits; for odd parity this XOR is inverted. The parity bit is computed at acceptance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance. data_out_Tx goes to 0 on the next cycle (latency 1 clk), and the divider is cleared.
  - START: line=0 for one bit period, then -> DATA.
  - DATA: line=shift[0]; at each bit boundary shift right and increment bit_cnt. After 7 or 8 bits, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: line=parity bit for one bit period, then -> STOP.
  - STOP: line=1 for 1 or 2 bit periods, then -> IDLE with tx_done=1 for exactly one cycle.
- tx_ready=1 only in IDLE. tx_busy = not IDLE.
- Back-to-back frames: if tx_valid is held high, the next byte is accepted the cycle after returning to IDLE (tx_done cycle = first ready cycle). The line stays high for at least that one cycle.
- tx_valid while busy is ignored; no byte is queued.
- Reset mid-frame: on the next edge the line returns to 1 and all state resets. The aborted frame is not resumed.
- Frame length in bits = 1 + (7|8) + (0|1) + (1|2), i.e. 9 to 12 bits. Total cycles from acceptance to tx_done = 1 + bits × BIT_CYC.

Test Plan:
- 9600 baud, 8N1, byte 0x55 -> line sequence 0,1,0,1,0,1,0,1,0,1; each bit lasts CLK_FREQ/9600 cycles; tx_done pulses once, 10 bit periods after acceptance.
- 1200 baud, 7 data bits, even parity, 2 stop bits, byte 0x41 -> bits 0,1,0,0,0,0,0,1,0,1,1 (parity 0 because 0x41 has an even count of ones); 11 bit periods.
- Odd parity, 8 bits, byte 0xFF -> parity bit=1; the frame has 11 bits at the selected baud.
- Two consecutive bytes 0xA5 then 0x3C with tx_valid held high -> the second START begins exactly 1 cycle after the first tx_done; tx_ready is low during each frame.
- bd_sel changed from 11 to 00 mid-frame -> the current frame finishes at 9600; the next frame runs at 1200.
- rst asserted during the DATA state -> the next cycle has data_out_Tx=1, tx_ready=1, tx_busy=0, and no tx_done pulse.
